ad_capture: RTL and testbench

Capture front end for the four external 12-bit diagnostic A/D channels (capacitor voltage/current, load voltage/current). Generates the converter chip-select and frame timing, shifts in four serial lanes clocked by `clk` (driven to the board as `ad_sclk`), and presents parallel samples with a one-cycle valid strobe. Sits between the `ad_*` pads and the blaster control logic, which consumes the samples for charge, PWM and continuity decisions.

---
 rtl/ad_pkg.sv | 25 ++
 rtl/ad_lane_shift.sv | 77 +++++++
 rtl/ad_capture.sv | 192 +++++++++++++++++++
 tb/tb_ad_capture.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ad_pkg
// Brief    : Shared types and constants for the diagnostic A/D capture path.
// Revision : 1.0 - initial release
// ============================================================================
package ad_pkg;

    typedef logic [11:0] ad_sample_t;

    localparam int NUM_CH    = 4;
    localparam int CH_CAP_V  = 0;
    localparam int CH_CAP_I  = 1;
    localparam int CH_LOAD_V = 2;
    localparam int CH_LOAD_I = 3;

    localparam logic [7:0] ERR_MAX = 8'hFF;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CONV = 1'b1
    } ad_state_t;

endpackage
`default_nettype wire

// File: rtl/ad_lane_shift.sv
`default_nettype none
// ============================================================================
// Module   : ad_lane_shift
// Brief    : One serial A/D lane: input delay line, lead-bit error flag and
//            MSB-first sample shift register.
// Revision : 1.0 - initial release
// ============================================================================
module ad_lane_shift #(
    parameter int DATA_BITS = 12,
    parameter int DELAY     = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_sdata,
    input  logic                 i_lead_clr,
    input  logic                 i_lead_en,
    input  logic                 i_shift_en,
    output logic [DATA_BITS-1:0] o_data_next,
    output logic                 o_lead_err_next
);

    logic [DELAY-1:0]     dly_q;
    logic [DELAY-1:0]     dly_d;
    logic                 lead_err_q;
    logic                 lead_err_d;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;
    logic                 w_bit;

    always_comb begin
        dly_d    = dly_q;
        dly_d[0] = i_sdata;
        for (int k = 1; k < DELAY; k++) begin
            dly_d[k] = dly_q[k-1];
        end
    end

    assign w_bit = dly_q[DELAY-1];

    always_comb begin
        lead_err_d = lead_err_q;
        if (i_lead_clr) begin
            lead_err_d = 1'b0;
        end
        if (i_lead_en) begin
            lead_err_d = lead_err_d | w_bit;
        end
    end

    always_comb begin
        shift_d = shift_q;
        if (i_shift_en) begin
            shift_d[0] = w_bit;
            for (int k = 1; k < DATA_BITS; k++) begin
                shift_d[k] = shift_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dly_q      <= '0;
            lead_err_q <= 1'b0;
            shift_q    <= '0;
        end else begin
            dly_q      <= dly_d;
            lead_err_q <= lead_err_d;
            shift_q    <= shift_d;
        end
    end

    // Next-state values let the top publish on the same edge that takes the last bit.
    assign o_data_next     = shift_d;
    assign o_lead_err_next = lead_err_d;

endmodule
`default_nettype wire

// File: rtl/ad_capture.sv
`default_nettype none
// ============================================================================
// Module   : ad_capture
// Brief    : Four-lane 12-bit A/D capture front end: cs/frame timing, serial
//            shift-in and coherent parallel sample publish with error count.
// Revision : 1.0 - initial release
// ============================================================================
module ad_capture
    import ad_pkg::*;
#(
    parameter int DATA_BITS    = 12,
    parameter int LEAD_BITS    = 2,
    parameter int FRAME_CYCLES = 16,
    parameter int CONV_CYCLES  = 24,
    parameter int DELAY        = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    output logic                 ad_cs,
    input  logic [1:0]           ad_sdata_a,
    input  logic [1:0]           ad_sdata_b,
    output logic [DATA_BITS-1:0] cap_v,
    output logic [DATA_BITS-1:0] cap_i,
    output logic [DATA_BITS-1:0] load_v,
    output logic [DATA_BITS-1:0] load_i,
    output logic                 sample_valid,
    output logic                 frame_err,
    output logic [7:0]           err_count
);

    localparam int CW = $clog2(CONV_CYCLES + 1);

    localparam logic [CW-1:0] C_LAST    = CW'(CONV_CYCLES - 1);
    localparam logic [CW-1:0] C_FRAME   = CW'(FRAME_CYCLES);
    localparam logic [CW-1:0] C_LEAD_LO = CW'(DELAY);
    localparam logic [CW-1:0] C_DATA_LO = CW'(DELAY + LEAD_BITS);
    localparam logic [CW-1:0] C_DATA_HI = CW'(DELAY + LEAD_BITS + DATA_BITS);
    localparam logic [CW-1:0] C_PUB     = CW'(DELAY + LEAD_BITS + DATA_BITS - 1);

    if (LEAD_BITS + DATA_BITS > FRAME_CYCLES) begin : g_chk_frame
        $error("ad_capture: LEAD_BITS + DATA_BITS must not exceed FRAME_CYCLES");
    end
    if (DELAY + FRAME_CYCLES > CONV_CYCLES) begin : g_chk_conv
        $error("ad_capture: DELAY + FRAME_CYCLES must not exceed CONV_CYCLES");
    end
    if (DELAY < 1) begin : g_chk_delay
        $error("ad_capture: DELAY must be at least 1");
    end

    ad_state_t            state_q;
    ad_state_t            state_d;
    logic [CW-1:0]        cnt_q;
    logic [CW-1:0]        cnt_d;
    logic [CW-1:0]        w_cnt_inc;
    logic                 cs_q;
    logic                 cs_d;

    logic                 w_conv;
    logic                 w_lead_clr;
    logic                 w_lead_en;
    logic                 w_shift_en;
    logic                 w_publish;
    logic [NUM_CH-1:0]    w_lane_in;
    logic [NUM_CH-1:0]    w_lead_next;
    logic [DATA_BITS-1:0] w_data_next [NUM_CH];

    logic [DATA_BITS-1:0] sample_q [NUM_CH];
    logic [DATA_BITS-1:0] sample_d [NUM_CH];
    logic                 valid_q;
    logic                 valid_d;
    logic                 ferr_q;
    logic                 ferr_d;
    logic [7:0]           errcnt_q;
    logic [7:0]           errcnt_d;

    assign w_cnt_inc = cnt_q + CW'(1);

    // enable is only looked at in IDLE and on the last cycle of a conversion.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cs_d    = 1'b1;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = CONV;
                    cnt_d   = '0;
                    cs_d    = 1'b0;
                end
            end
            CONV: begin
                if (cnt_q == C_LAST) begin
                    cnt_d = '0;
                    if (enable) begin
                        cs_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = w_cnt_inc;
                    cs_d  = (w_cnt_inc >= C_FRAME);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cs_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cs_q    <= cs_d;
        end
    end

    assign w_conv     = (state_q == CONV);
    assign w_lead_clr = w_conv && (cnt_q == '0);
    assign w_lead_en  = w_conv && (cnt_q >= C_LEAD_LO) && (cnt_q < C_DATA_LO);
    assign w_shift_en = w_conv && (cnt_q >= C_DATA_LO) && (cnt_q < C_DATA_HI);
    assign w_publish  = w_conv && (cnt_q == C_PUB);

    assign w_lane_in[CH_CAP_V]  = ad_sdata_a[0];
    assign w_lane_in[CH_CAP_I]  = ad_sdata_a[1];
    assign w_lane_in[CH_LOAD_V] = ad_sdata_b[0];
    assign w_lane_in[CH_LOAD_I] = ad_sdata_b[1];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        ad_lane_shift #(
            .DATA_BITS (DATA_BITS),
            .DELAY     (DELAY)
        ) u_lane (
            .clk             (clk),
            .reset           (reset),
            .i_sdata         (w_lane_in[g]),
            .i_lead_clr      (w_lead_clr),
            .i_lead_en       (w_lead_en),
            .i_shift_en      (w_shift_en),
            .o_data_next     (w_data_next[g]),
            .o_lead_err_next (w_lead_next[g])
        );
    end

    always_comb begin
        sample_d = sample_q;
        valid_d  = w_publish;
        ferr_d   = w_publish && (|w_lead_next);
        errcnt_d = errcnt_q;
        if (w_publish) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                sample_d[ch] = w_data_next[ch];
            end
            if ((|w_lead_next) && (errcnt_q != ERR_MAX)) begin
                errcnt_d = errcnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                sample_q[ch] <= '0;
            end
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            errcnt_q <= '0;
        end else begin
            sample_q <= sample_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
            errcnt_q <= errcnt_d;
        end
    end

    assign ad_cs        = cs_q;
    assign cap_v        = sample_q[CH_CAP_V];
    assign cap_i        = sample_q[CH_CAP_I];
    assign load_v       = sample_q[CH_LOAD_V];
    assign load_i       = sample_q[CH_LOAD_I];
    assign sample_valid = valid_q;
    assign frame_err    = ferr_q;
    assign err_count    = errcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ad_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_ad_capture
// Brief    : Self-checking bench for ad_capture with a converter model that
//            answers each cs frame and a frame-level expectation queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ad_capture;

    localparam int DATA  = 12;
    localparam int LEAD  = 2;
    localparam int FRAME = 16;
    localparam int CONV  = 24;
    localparam int DLY   = 1;
    localparam int P_LAT = DLY + LEAD + DATA;

    typedef struct packed {
        logic [3:0][11:0] d;
        logic [3:0][1:0]  lead;
    } frame_t;

    typedef struct packed {
        logic [3:0][11:0] d;
        logic             err;
        logic [31:0]      due;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        ad_cs;
    logic [1:0]  ad_sdata_a;
    logic [1:0]  ad_sdata_b;
    logic [11:0] cap_v;
    logic [11:0] cap_i;
    logic [11:0] load_v;
    logic [11:0] load_i;
    logic        sample_valid;
    logic        frame_err;
    logic [7:0]  err_count;

    logic [3:0][11:0] dut_s;
    assign dut_s = {load_i, load_v, cap_i, cap_v};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int frames   = 0;
    int fall_cyc = 0;
    int model_err = 0;
    bit chk_gap  = 1'b0;
    logic [3:0][11:0] last_pub = '0;
    frame_t stim_q[$];
    exp_t   exp_q[$];

    ad_capture #(
        .DATA_BITS    (DATA),
        .LEAD_BITS    (LEAD),
        .FRAME_CYCLES (FRAME),
        .CONV_CYCLES  (CONV),
        .DELAY        (DLY)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .ad_cs        (ad_cs),
        .ad_sdata_a   (ad_sdata_a),
        .ad_sdata_b   (ad_sdata_b),
        .cap_v        (cap_v),
        .cap_i        (cap_i),
        .load_v       (load_v),
        .load_i       (load_i),
        .sample_valid (sample_valid),
        .frame_err    (frame_err),
        .err_count    (err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input logic ok, input string name,
                         input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic frame_t mk(input logic [11:0] a0, input logic [11:0] a1,
                                  input logic [11:0] a2, input logic [11:0] a3,
                                  input logic [1:0] l3);
        frame_t r;
        r.d    = {a3, a2, a1, a0};
        r.lead = {l3, 6'b0};
        return r;
    endfunction

    // Bit i of a converter frame: lead bits, data MSB first, then idle ones.
    function automatic logic pin_bit(input frame_t f, input int l, input int i);
        if (i < LEAD) return f.lead[l][i];
        if (i < LEAD + DATA) return f.d[l][DATA-1-(i-LEAD)];
        return 1'b1;
    endfunction

    // Converter model: starts a frame on each cs fall and drives its bits.
    initial begin
        frame_t cur;
        exp_t   e;
        logic   prev_cs;
        int     idx;
        int     low_run;
        int     hi_run;
        cur = '0; prev_cs = 1'b1; idx = 0; low_run = 0; hi_run = 0;
        ad_sdata_a = 2'b11;
        ad_sdata_b = 2'b11;
        forever begin
            @(posedge clk);
            #1;
            if (ad_cs === 1'b0) begin
                if (prev_cs === 1'b1) begin
                    if (chk_gap) check(hi_run == CONV - FRAME, "cs_high_gap", hi_run, CONV - FRAME);
                    cur      = (stim_q.size() > 0) ? stim_q.pop_front() : '0;
                    idx      = 0;
                    low_run  = 0;
                    fall_cyc = cyc;
                    frames++;
                    e.d   = cur.d;
                    e.err = |cur.lead;
                    e.due = 32'(cyc + P_LAT);
                    exp_q.push_back(e);
                end else begin
                    idx++;
                end
                low_run++;
                ad_sdata_a = {pin_bit(cur, 1, idx), pin_bit(cur, 0, idx)};
                ad_sdata_b = {pin_bit(cur, 3, idx), pin_bit(cur, 2, idx)};
            end else begin
                if (prev_cs === 1'b0) begin
                    if (reset === 1'b0) check(low_run == FRAME, "cs_low_len", low_run, FRAME);
                    hi_run = 0;
                end
                hi_run++;
                ad_sdata_a = 2'b11;
                ad_sdata_b = 2'b11;
            end
            prev_cs = ad_cs;
        end
    end

    // Cycle-by-cycle compare against the expected frame queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset === 1'b0) begin
                if (exp_q.size() > 0 && exp_q[0].due == 32'(cyc)) begin
                    e = exp_q.pop_front();
                    check(sample_valid === 1'b1, "valid_at_due", sample_valid, 1);
                    for (int ch = 0; ch < 4; ch++) begin
                        check(dut_s[ch] === e.d[ch], $sformatf("sample_ch%0d", ch), dut_s[ch], e.d[ch]);
                    end
                    check(frame_err === e.err, "frame_err", frame_err, e.err);
                    if (e.err && model_err < 255) model_err++;
                    last_pub = e.d;
                end else begin
                    check(sample_valid === 1'b0, "valid_unexpected", sample_valid, 0);
                    check(frame_err === 1'b0, "frame_err_idle", frame_err, 0);
                    check(dut_s === last_pub, "sample_hold", dut_s, last_pub);
                end
                check(err_count === 8'(model_err), "err_count", err_count, model_err);
            end
        end
    end

    task automatic wait_valid(input int max, output int at);
        at = -1;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (sample_valid === 1'b1) begin
                at = cyc;
                break;
            end
        end
        check(at >= 0, "valid_timeout", at, 0);
    endtask

    task automatic wait_cnt(input int f0, input int n);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (frames > f0 && cyc - fall_cyc == n) begin
                found = 1'b1;
                break;
            end
        end
        check(found, "cnt_timeout", found, 1);
    endtask

    task automatic pulse_enable();
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
    endtask

    initial begin
        int     at;
        int     prev;
        int     f0;
        int     lows;
        frame_t f;

        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check(ad_cs === 1'b1, "rst_cs", ad_cs, 1);
        check(dut_s === '0, "rst_samples", dut_s, 0);
        check(err_count === 8'd0, "rst_err_count", err_count, 0);
        check(sample_valid === 1'b0, "rst_valid", sample_valid, 0);
        reset = 1'b0;
        lows  = 0;
        repeat (100) begin
            @(negedge clk);
            if (ad_cs !== 1'b1) lows++;
        end
        check(lows == 0, "idle_no_cs", lows, 0);

        // Single frame from a one-cycle enable pulse
        stim_q.push_back(mk(12'hABC, 12'h123, 12'hFFF, 12'h000, 2'b00));
        f0 = frames;
        pulse_enable();
        wait_valid(40, at);
        check(at - fall_cyc == 15, "single_latency", at - fall_cyc, 15);
        check(cap_v === 12'hABC, "single_cap_v", cap_v, 12'hABC);
        check(cap_i === 12'h123, "single_cap_i", cap_i, 12'h123);
        check(load_v === 12'hFFF, "single_load_v", load_v, 12'hFFF);
        check(load_i === 12'h000, "single_load_i", load_i, 12'h000);
        check(frame_err === 1'b0, "single_frame_err", frame_err, 0);
        repeat (30) @(negedge clk);
        check(frames - f0 == 1, "single_frame_count", frames - f0, 1);
        check(ad_cs === 1'b1, "single_back_idle", ad_cs, 1);

        // Continuous conversions with incrementing data
        for (int k = 0; k < 10; k++) begin
            stim_q.push_back(mk(12'((k + 1) * 12'h111), 12'((k + 1) * 12'h111 + 1),
                                12'((k + 1) * 12'h111 + 2), 12'((k + 1) * 12'h111 + 3), 2'b00));
        end
        f0   = frames;
        prev = 0;
        @(negedge clk);
        enable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            wait_valid(40, at);
            if (k > 0) check(at - prev == 24, "cont_period", at - prev, 24);
            else chk_gap = 1'b1;
            prev = at;
            if (k == 9) check(cap_v === 12'hAAA, "cont_last_cap_v", cap_v, 12'hAAA);
        end
        enable  = 1'b0;
        chk_gap = 1'b0;
        repeat (30) @(negedge clk);
        check(frames - f0 == 10, "cont_frame_count", frames - f0, 10);

        // Lead error on load_i, lead bit 1
        stim_q.push_back(mk(12'h111, 12'h222, 12'h333, 12'h444, 2'b10));
        pulse_enable();
        wait_valid(40, at);
        check(frame_err === 1'b1, "lead_frame_err", frame_err, 1);
        check(err_count === 8'd1, "lead_err_count", err_count, 1);
        check(load_i === 12'h444, "lead_load_i", load_i, 12'h444);
        repeat (30) @(negedge clk);

        // 300 errored frames saturate the counter
        for (int k = 0; k < 300; k++) begin
            f = '0;
            for (int ch = 0; ch < 4; ch++) f.d[ch] = 12'($urandom);
            f.lead[$urandom_range(0, 3)] = 2'($urandom_range(1, 3));
            stim_q.push_back(f);
        end
        f0 = frames;
        @(negedge clk);
        enable = 1'b1;
        for (int k = 0; k < 300; k++) begin
            wait_valid(40, at);
            if (k == 252) check(err_count === 8'd254, "sat_pre", err_count, 254);
        end
        enable = 1'b0;
        repeat (30) @(negedge clk);
        check(err_count === 8'd255, "sat_err_count", err_count, 255);
        check(frames - f0 == 300, "sat_frame_count", frames - f0, 300);

        // Enable dropped at cnt=5 still completes the frame
        stim_q.push_back(mk(12'h5A5, 12'hA5A, 12'h0F0, 12'hF0F, 2'b00));
        f0 = frames;
        @(negedge clk);
        enable = 1'b1;
        wait_cnt(f0, 5);
        enable = 1'b0;
        wait_valid(40, at);
        check(at - fall_cyc == 15, "drop_latency", at - fall_cyc, 15);
        check(cap_v === 12'h5A5, "drop_cap_v", cap_v, 12'h5A5);
        check(load_i === 12'hF0F, "drop_load_i", load_i, 12'hF0F);
        lows = 0;
        repeat (40) begin
            @(negedge clk);
            if (ad_cs !== 1'b1) lows++;
        end
        check(lows == 0, "drop_cs_high", lows, 0);
        check(frames - f0 == 1, "drop_frame_count", frames - f0, 1);

        // Reset at cnt=8 aborts the frame
        stim_q.push_back(mk(12'hDEA, 12'hDBE, 12'hEF0, 12'h0FF, 2'b11));
        f0 = frames;
        @(negedge clk);
        enable = 1'b1;
        wait_cnt(f0, 8);
        reset = 1'b1;
        exp_q.delete();
        stim_q.delete();
        last_pub  = '0;
        model_err = 0;
        #1;
        check(ad_cs === 1'b1, "mid_rst_cs", ad_cs, 1);
        check(dut_s === '0, "mid_rst_samples", dut_s, 0);
        check(err_count === 8'd0, "mid_rst_err_count", err_count, 0);
        check(sample_valid === 1'b0, "mid_rst_valid", sample_valid, 0);
        repeat (3) @(negedge clk);
        stim_q.push_back(mk(12'h321, 12'h654, 12'h987, 12'hCBA, 2'b00));
        f0 = frames;
        reset = 1'b0;
        wait_valid(40, at);
        check(at - fall_cyc == 15, "rst_fresh_latency", at - fall_cyc, 15);
        check(cap_v === 12'h321, "rst_fresh_cap_v", cap_v, 12'h321);
        check(load_i === 12'hCBA, "rst_fresh_load_i", load_i, 12'hCBA);
        check(frame_err === 1'b0, "rst_fresh_frame_err", frame_err, 0);
        enable = 1'b0;
        repeat (40) @(negedge clk);
        check(frames - f0 == 1, "rst_fresh_frames", frames - f0, 1);
        check(exp_q.size() == 0, "pending_frames", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
